// File: rtl/fifo_ctrl.sv
// Pointer and occupancy engine for an external FIFO storage array.
// Qualifies raw push/pop requests into memory strobes and decodes status flags.
module fifo_ctrl #(
    parameter int MEM_SIZE = 8,
    parameter int PTR      = 3,
    parameter int AF_TH    = 6,
    parameter int AE_TH    = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           push_req,
    input  logic           pop_req,
    output logic           push,
    output logic           pop,
    output logic [PTR-1:0] wr_ptr,
    output logic [PTR-1:0] rd_ptr,
    output logic [PTR:0]   count,
    output logic           full,
    output logic           empty,
    output logic           almost_full,
    output logic           almost_empty,
    output logic           overflow,
    output logic           underflow
);

    localparam logic [PTR:0] FULL_CNT = (PTR+1)'(MEM_SIZE);
    localparam logic [PTR:0] AF_CNT   = (PTR+1)'(AF_TH);
    localparam logic [PTR:0] AE_CNT   = (PTR+1)'(AE_TH);

    logic [PTR-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR:0]   count_q, count_d;
    logic           overflow_q, overflow_d;
    logic           underflow_q, underflow_d;

    // Request/strobe contract: a request is honoured in the cycle it is raised;
    // push/pop are the accepted subset and take effect at the next posedge.
    // A push into a full FIFO is accepted only when a pop frees a slot the same cycle.
    assign pop  = reset & pop_req & ~empty;
    assign push = reset & push_req & (~full | pop);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (push_req && !push) overflow_d  = 1'b1;
        if (pop_req && !pop)   underflow_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Flags decode straight off the registered count, so they track it with no lag.
    assign wr_ptr       = wr_ptr_q;
    assign rd_ptr       = rd_ptr_q;
    assign count        = count_q;
    assign full         = (count_q == FULL_CNT);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_CNT);
    assign almost_empty = (count_q <= AE_CNT);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl: emulates the storage array, tracks expected read data in a
// queue and compares pointers, count and flags against a small reference model.
module tb_fifo_ctrl;

    localparam int PTR = 3;

    logic           clk = 1'b0;
    logic           reset;
    logic           push_req, pop_req;
    logic           push, pop;
    logic [PTR-1:0] wr_ptr, rd_ptr;
    logic [PTR:0]   count;
    logic           full, empty, almost_full, almost_empty, overflow, underflow;

    fifo_ctrl #(.MEM_SIZE(8), .PTR(3), .AF_TH(6), .AE_TH(2)) dut (
        .clk(clk), .reset(reset),
        .push_req(push_req), .pop_req(pop_req),
        .push(push), .pop(pop),
        .wr_ptr(wr_ptr), .rd_ptr(rd_ptr), .count(count),
        .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // emulated storage array and scoreboard
    logic [7:0] mem [8];
    logic [7:0] exp_q [$];

    // reference model
    logic [2:0] m_wr, m_rd;
    int         m_count;
    logic       m_ovf, m_unf;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        m_wr = '0; m_rd = '0; m_count = 0; m_ovf = 1'b0; m_unf = 1'b0;
        exp_q.delete();
    endtask

    task automatic check_state(input string tag);
        check({tag, ".wr_ptr"}, wr_ptr, m_wr);
        check({tag, ".rd_ptr"}, rd_ptr, m_rd);
        check({tag, ".count"}, count, m_count);
        check({tag, ".full"}, full, m_count == 8);
        check({tag, ".empty"}, empty, m_count == 0);
        check({tag, ".afull"}, almost_full, m_count >= 6);
        check({tag, ".aempty"}, almost_empty, m_count <= 2);
        check({tag, ".ovf"}, overflow, m_ovf);
        check({tag, ".unf"}, underflow, m_unf);
        check({tag, ".inv"}, 3'(wr_ptr - rd_ptr), count[2:0]);
    endtask

    // One clock of stimulus: drive after negedge, check strobes, then registered state.
    task automatic cycle(input string tag, input logic preq, input logic qreq);
        logic       exp_pop, exp_push;
        logic [7:0] dat;
        @(negedge clk);
        push_req = preq;
        pop_req  = qreq;
        dat      = 8'($urandom_range(0, 255));
        #1;
        exp_pop  = qreq && (m_count != 0);
        exp_push = preq && ((m_count != 8) || exp_pop);
        check({tag, ".push"}, push, exp_push);
        check({tag, ".pop"}, pop, exp_pop);
        if (pop) begin
            check({tag, ".q_nonempty"}, exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check({tag, ".rdata"}, mem[rd_ptr], exp_q.pop_front());
        end
        if (push) mem[wr_ptr] = dat;
        if (exp_push) exp_q.push_back(dat);
        if (exp_push) m_wr = m_wr + 3'd1;
        if (exp_pop)  m_rd = m_rd + 3'd1;
        if (exp_push && !exp_pop) m_count++;
        if (exp_pop && !exp_push) m_count--;
        if (preq && !exp_push) m_ovf = 1'b1;
        if (qreq && !exp_pop)  m_unf = 1'b1;
        @(posedge clk);
        #1;
        check_state(tag);
        push_req = 1'b0;
        pop_req  = 1'b0;
    endtask

    // Assert reset between edges with requests pending; outputs must clear at once.
    task automatic mid_reset(input string tag);
        @(negedge clk);
        push_req = 1'b1;
        pop_req  = 1'b1;
        #2 reset = 1'b0;
        #1;
        model_reset();
        check({tag, ".push_rst"}, push, 0);
        check({tag, ".pop_rst"}, pop, 0);
        check_state(tag);
        @(negedge clk);
        push_req = 1'b0;
        pop_req  = 1'b0;
        reset    = 1'b1;
    endtask

    initial begin
        reset    = 1'b0;
        push_req = 1'b0;
        pop_req  = 1'b0;
        model_reset();
        #12;
        check("por.push", push, 0);
        check("por.pop", pop, 0);
        check_state("por");
        @(negedge clk);
        reset = 1'b1;

        // fill to full, then one refused push
        for (int i = 0; i < 8; i++) cycle("fill", 1'b1, 1'b0);
        cycle("ovf", 1'b1, 1'b0);

        // drain to empty, then one refused pop
        for (int i = 0; i < 8; i++) cycle("drain", 1'b0, 1'b1);
        cycle("unf", 1'b0, 1'b1);

        // steady state at count=3 with simultaneous push/pop
        mid_reset("rst1");
        for (int i = 0; i < 3; i++) cycle("pre3", 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) cycle("both3", 1'b1, 1'b1);

        // full with simultaneous push/pop: both accepted, no overflow
        for (int i = 0; i < 5; i++) cycle("to_full", 1'b1, 1'b0);
        cycle("full_both", 1'b1, 1'b1);
        check("full_both.no_ovf", overflow, 0);

        // empty with simultaneous push/pop: push only, underflow set
        mid_reset("rst2");
        cycle("empty_both", 1'b1, 1'b1);
        check("empty_both.count1", count, 1);

        // reset at count=5, then the first push must target address 0
        for (int i = 0; i < 4; i++) cycle("to5", 1'b1, 1'b0);
        mid_reset("rst5");
        @(negedge clk);
        push_req = 1'b1;
        #1;
        check("after_rst.wr_addr", wr_ptr, 0);
        push_req = 1'b0;
        cycle("after_rst", 1'b1, 1'b0);

        // random traffic
        for (int i = 0; i < 300; i++)
            cycle("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Control and pointer engine that drives the FIFO storage array: it generates wr_ptr/rd_ptr and the qualified push/pop strobes the array consumes, and tracks occupancy.
- Sits between the upstream writer / downstream reader and the memory.
- Raw requests in; qualified memory strobes, pointers and status flags out.

Parameters:
- MEM_SIZE, 8, number of FIFO entries; must equal 2**PTR.
- PTR, 3, pointer width in bits.
- AF_TH, 6, almost_full asserts when count >= AF_TH.
- AE_TH, 2, almost_empty asserts when count <= AE_TH.

Ports:
- clk  input  1  single clock, all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- push_req  input  1  writer requests a write this cycle.
- pop_req  input  1  reader requests a read this cycle.
- push  output  1  qualified write strobe to memory (combinational).
- pop  output  1  qualified read strobe to memory (combinational).
- wr_ptr  output  PTR  memory write address.
- rd_ptr  output  PTR  memory read address.
- count  output  PTR+1  current occupancy, 0..MEM_SIZE.
- full  output  1  count == MEM_SIZE.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AF_TH.
- almost_empty  output  1  count <= AE_TH.
- overflow  output  1  sticky: write request refused.
- underflow  output  1  sticky: read request refused.

Behaviour:
- Reset (reset low, asynchronous, takes effect immediately and regardless of clk):
  - wr_ptr=0, rd_ptr=0, count=0, overflow=0, underflow=0.
  - empty=1, full=0, almost_empty=1, almost_full=0.
  - push=0, pop=0 while reset is low.
- Qualification (combinational, same cycle as the request):
  - pop = pop_req & !empty.
  - push = push_req & (!full | pop).
  - Read data leaves memory in the same cycle pop is high, at the current rd_ptr.
- Sequential update, posedge clk, reset high:
  - push accepted: wr_ptr <= wr_ptr+1, modulo 2**PTR (natural wrap 7 -> 0).
  - pop accepted: rd_ptr <= rd_ptr+1, same wrap rule.
  - count: +1 if push only; -1 if pop only; unchanged if both or neither.
- Flags full, empty, almost_full and almost_empty are decoded from the registered count: no extra latency, valid the cycle after the count changes.
- Boundary conditions:
  - Full, push_req & pop_req: both accepted; write lands in the slot being freed next edge, count stays MEM_SIZE.
  - Full, push_req only: push=0, pointers hold, overflow <= 1.
  - Empty, pop_req & push_req: push accepted, pop=0, underflow <= 1, count becomes 1.
  - Empty, pop_req only: pop=0, underflow <= 1.
  - overflow and underflow are sticky and are cleared only by reset.
- Reset mid-operation: all state returns to reset values immediately; any in-flight request is dropped; the first accepted push after release writes address 0.
- Invariant: (wr_ptr - rd_ptr) mod 2**PTR == count mod 2**PTR at all times.

Test Plan:
- Reset release, then 8 push_req cycles with no pop -> wr_ptr steps 0..7 and wraps to 0; count=8; full=1 after the 8th edge; almost_full=1 from count=6; push=0 on a 9th request and overflow=1.
- From full, 8 pop_req cycles -> pop=1 each cycle; rd_ptr steps 0..7 then wraps to 0; empty=1 and almost_empty=1 at count<=2; a 9th pop gives pop=0 and underflow=1.
- Count=3, push_req and pop_req held together for 10 cycles -> count stays 3; both pointers advance 10 (mod 8); wr_ptr - rd_ptr = 3 throughout.
- Full, push_req & pop_req in the same cycle -> push=1, pop=1, count stays 8, overflow stays 0.
- Empty, push_req & pop_req in the same cycle -> push=1, pop=0, count=1, underflow=1.
- Count=5, reset asserted low between clock edges -> all outputs at reset values before the next posedge; after release, the first push writes wr_ptr=0.
